// File: rtl/lc3b_mem_arbiter.sv
// Single-port memory arbiter sharing one memory port between IF (read-only) and MEM (read/write).
// Define LC3B_ARB_ROUND_ROBIN_EN for round-robin on contention; otherwise data always wins.
module lc3b_mem_arbiter #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_read,
  input  logic [DATA_W-1:0] if_address,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [1:0]        d_byte_enable,
  input  logic [DATA_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [1:0]        mem_byte_enable,
  output logic [DATA_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_FETCH = 2'b01;
  localparam logic [1:0] S_DATA  = 2'b10;

  logic [1:0] state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       if_req, d_req;

  assign if_req = if_read;
  assign d_req  = d_read | d_write;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      S_IDLE: begin
        if (if_req && d_req) begin
`ifdef LC3B_ARB_ROUND_ROBIN_EN
          state_d = last_grant_q ? S_FETCH : S_DATA;
`else
          state_d = S_DATA;
`endif
        end else if (d_req) begin
          state_d = S_DATA;
        end else if (if_req) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (mem_resp) begin
          state_d      = S_IDLE;
          last_grant_d = 1'b0;
        end else if (!if_req) begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (mem_resp) begin
          state_d      = S_IDLE;
          last_grant_d = 1'b1;
        end else if (!d_req) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Address/data are passed through unregistered; requesters hold them stable while granted.
  always_comb begin
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 2'b00;
    mem_address     = '0;
    mem_wdata       = '0;
    if_resp         = 1'b0;
    if_rdata        = '0;
    d_resp          = 1'b0;
    d_rdata         = '0;
    case (state_q)
      S_FETCH: begin
        mem_read        = if_read;
        mem_byte_enable = 2'b11;
        mem_address     = if_address;
        if_resp         = mem_resp;
        if_rdata        = mem_rdata;
      end
      S_DATA: begin
        mem_read        = d_read & ~d_write;
        mem_write       = d_write;
        mem_byte_enable = d_write ? d_byte_enable : 2'b11;
        mem_address     = d_address;
        mem_wdata       = d_wdata;
        d_resp          = mem_resp;
        d_rdata         = mem_rdata;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Directed bench for lc3b_mem_arbiter; honours LC3B_ARB_ROUND_ROBIN_EN for contention expectations.
module tb_lc3b_mem_arbiter;

  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_read;
  logic [DATA_W-1:0] if_address;
  logic [DATA_W-1:0] if_rdata;
  logic              if_resp;
  logic              d_read, d_write;
  logic [1:0]        d_byte_enable;
  logic [DATA_W-1:0] d_address, d_wdata, d_rdata;
  logic              d_resp;
  logic              mem_read, mem_write;
  logic [1:0]        mem_byte_enable;
  logic [DATA_W-1:0] mem_address, mem_wdata, mem_rdata;
  logic              mem_resp;
  logic              busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lc3b_mem_arbiter #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_read(if_read), .if_address(if_address), .if_rdata(if_rdata), .if_resp(if_resp),
    .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
    .d_address(d_address), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  logic [DATA_W-1:0] exp_addr [4];

  initial begin
    rst_n = 1'b0; if_read = 0; if_address = '0; d_read = 0; d_write = 0;
    d_byte_enable = 2'b00; d_address = '0; d_wdata = '0; mem_rdata = '0; mem_resp = 0;

    // Reset state
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_addr", mem_address, 0);
    chk("rst_resps", {if_resp, d_resp}, 0);

    // Lone fetch with 3-cycle memory latency
    if_read = 1; if_address = 16'h3000;
    #1 chk("fetch_idle_rd", mem_read, 0);
    step();
    chk("fetch_rd", mem_read, 1);
    chk("fetch_addr", mem_address, 16'h3000);
    chk("fetch_be", mem_byte_enable, 2'b11);
    chk("fetch_busy", busy, 1);
    step();
    step();
    mem_resp = 1; mem_rdata = 16'h1234;
    #1;
    chk("fetch_resp", if_resp, 1);
    chk("fetch_rdata", if_rdata, 16'h1234);
    chk("fetch_d_resp", d_resp, 0);
    chk("fetch_d_rdata", d_rdata, 0);
    step();
    mem_resp = 0; if_read = 0;
    #1;
    chk("fetch_after_busy", busy, 0);
    chk("fetch_after_resp", if_resp, 0);

    // Byte store
    d_write = 1; d_address = 16'h4001; d_byte_enable = 2'b10; d_wdata = 16'hAB00;
    step();
    chk("st_wr", {mem_write, mem_read}, 2'b10);
    chk("st_be", mem_byte_enable, 2'b10);
    chk("st_wdata", mem_wdata, 16'hAB00);
    chk("st_addr", mem_address, 16'h4001);
    mem_resp = 1;
    #1;
    chk("st_resp", {d_resp, if_resp}, 2'b10);
    step();
    mem_resp = 0; d_write = 0;
    #1 chk("st_after_busy", busy, 0);

    // Read and write together: write wins
    d_read = 1; d_write = 1; d_byte_enable = 2'b01; d_address = 16'h4100;
    step();
    chk("rw_strobes", {mem_write, mem_read}, 2'b10);
    chk("rw_be", mem_byte_enable, 2'b01);
    mem_resp = 1;
    #1 chk("rw_resp", d_resp, 1);
    step();
    mem_resp = 0; d_read = 0; d_write = 0;

    // mem_resp in IDLE is ignored
    mem_resp = 1; mem_rdata = 16'hBEEF;
    #1;
    chk("idle_resp", {if_resp, d_resp}, 0);
    chk("idle_rdata", {if_rdata, d_rdata}, 0);
    step();
    mem_resp = 0;

    // Contention: restart from reset so last_grant is 0
    do_reset();
    if_read = 1; if_address = 16'h1000;
    d_read = 1; d_address = 16'h2000;
`ifdef LC3B_ARB_ROUND_ROBIN_EN
    exp_addr = '{16'h2000, 16'h1000, 16'h2000, 16'h1000};
`else
    exp_addr = '{16'h2000, 16'h2000, 16'h2000, 16'h2000};
`endif
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("cont_grant%0d", i), mem_address, exp_addr[i]);
      mem_resp = 1; mem_rdata = 16'h0A00 + 16'(i);
      #1;
      chk($sformatf("cont_resp%0d", i), {if_resp, d_resp},
          (exp_addr[i] == 16'h2000) ? 2'b01 : 2'b10);
      step();
      mem_resp = 0;
      #1 chk($sformatf("cont_idle%0d", i), busy, 0);
    end
    d_read = 0;
    step();
    chk("cont_fetch_after", {mem_read, mem_address}, {1'b1, 16'h1000});
    mem_resp = 1;
    #1 chk("cont_fetch_resp", if_resp, 1);
    step();
    mem_resp = 0; if_read = 0;

    // Reset mid-access
    d_read = 1; d_address = 16'h5000;
    step();
    chk("rma_busy", {busy, mem_read}, 2'b11);
    rst_n = 0;
    step();
    chk("rma_outs", {busy, mem_read, mem_write, mem_byte_enable}, 0);
    chk("rma_addr", mem_address, 0);
    mem_resp = 1; mem_rdata = 16'hFFFF;
    #1;
    chk("rma_no_resp", d_resp, 0);
    chk("rma_rdata", d_rdata, 0);
    step();
    mem_resp = 0; d_read = 0; rst_n = 1;
    step();

    // Abort fetch
    if_read = 1; if_address = 16'h3100;
    step();
    chk("abort_rd", mem_read, 1);
    if_read = 0;
    #1 chk("abort_rd_drop", mem_read, 0);
    step();
    chk("abort_idle", busy, 0);
    mem_resp = 1;
    #1 chk("abort_no_resp", if_resp, 0);
    step();
    mem_resp = 0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lc3b_mem_arbiter.md
# lc3b_mem_arbiter

Single-port memory arbiter for the pipelined LC-3b core. It shares one physical memory port between the instruction-fetch stage (read-only) and the MEM stage (read/write). It sequences each access as a hold-until-response handshake and routes the response back to the granted requester only. The arbiter sits between the IF/MEM stage memory outputs and the external memory interface. Stage stall logic uses its `*_resp` outputs.

## Interface
Parameters:
- `DATA_W`, default 16: word width of addresses and data (the LC-3b word).

Ports:
- `clk` input, 1: single clock; all state updates on its rising edge.
- `rst_n` input, 1: reset, synchronous, active-low.
- `if_read` input, 1: fetch request; held high until `if_resp`.
- `if_address` input, DATA_W: fetch address.
- `if_rdata` output, DATA_W: fetch read data; valid when `if_resp`=1.
- `if_resp` output, 1: fetch access complete (one-cycle pulse).
- `d_read` input, 1: MEM-stage load request; held until `d_resp`.
- `d_write` input, 1: MEM-stage store request; held until `d_resp`.
- `d_byte_enable` input, 2: store byte lanes, [1]=high byte, [0]=low byte.
- `d_address` input, DATA_W: data address.
- `d_wdata` input, DATA_W: store data.
- `d_rdata` output, DATA_W: load data; valid when `d_resp`=1.
- `d_resp` output, 1: data access complete (one-cycle pulse).
- `mem_read` output, 1: physical memory read strobe.
- `mem_write` output, 1: physical memory write strobe.
- `mem_byte_enable` output, 2: physical byte enables.
- `mem_address` output, DATA_W: physical address.
- `mem_wdata` output, DATA_W: physical write data.
- `mem_rdata` input, DATA_W: physical read data.
- `mem_resp` input, 1: physical access done; asserted for one cycle.
- `busy` output, 1: high whenever the state is not IDLE.

## Operation
- States are IDLE, FETCH and DATA. `last_grant` is a 1-bit register (0=fetch, 1=data).
- **IDLE:** all `mem_*` outputs are 0. At the clock edge:
  - If a data request (`d_read|d_write`) is pending and no fetch request is pending, go to DATA.
  - If a fetch request is pending and no data request is pending, go to FETCH.
  - If both are pending, resolve per Configuration.
  - With no request pending, stay in IDLE.
- **FETCH:**
  - Drives `mem_read`=`if_read`, `mem_address`=`if_address`, `mem_byte_enable`=2'b11, `mem_write`=0, `mem_wdata`=0.
- **DATA:**
  - Drives `mem_read`=`d_read & ~d_write` and `mem_write`=`d_write`. Write wins if both are set; the read is dropped.
  - Drives `mem_address`=`d_address` and `mem_wdata`=`d_wdata`.
  - `mem_byte_enable`=`d_byte_enable` on a write and 2'b11 on a read.
- **Response routing:**
  - In the granted state, `<req>_resp`=`mem_resp` and `<req>_rdata`=`mem_rdata`, passed through combinationally.
  - The non-granted requester sees resp=0 and rdata=0.
  - On `mem_resp`=1: return to IDLE and set `last_grant` to the served requester.
- **Abort:** if the granted requester drops its request before `mem_resp`, return to IDLE at the next edge. Strobes are 0 from that cycle.
- **Ignored responses:** `mem_resp` in IDLE is ignored and produces no `*_resp` pulse.
- **Reset:** while `rst_n`=0 at an edge, the next state is IDLE and `last_grant` is 0.
  - From the following cycle, all strobes, resps, rdata and `busy` are 0.
  - Reset mid-access abandons the access without a response pulse.

## Timing
- Arbitration takes one cycle: a request first seen at edge N drives the `mem_*` strobes from cycle N+1.
- Response passthrough has zero latency: `*_resp` is high in the same cycle as `mem_resp`.
- After every access there is at least one IDLE cycle. Back-to-back accesses are therefore spaced by memory latency + 1 cycle.
- A requester's inputs must be stable while granted. The arbiter does not register the address or data.
- Output values under reset, defined above:
  - `mem_read`/`mem_write`=0, `mem_byte_enable`=0, `mem_address`/`mem_wdata`=0.
  - `if_resp`/`d_resp`=0, `if_rdata`/`d_rdata`=0, `busy`=0.

## Configuration
- `LC3B_ARB_ROUND_ROBIN_EN` defined: on contention in IDLE, grant the requester opposite to `last_grant`. This alternates fetch and data under sustained contention.
- `LC3B_ARB_ROUND_ROBIN_EN` undefined: on contention, DATA always wins (fixed priority to the older instruction). `last_grant` is still maintained but does not affect arbitration.

## Test plan
- **Lone fetch:** `if_read`=1, `if_address`=0x3000, memory answers after 3 cycles with 0x1234.
  - `mem_read` is high from the cycle after the request.
  - `if_resp`=1 with `if_rdata`=0x1234 for one cycle; `d_resp` stays 0; IDLE follows.
- **Byte store:** `d_write`=1, `d_address`=0x4001, `d_byte_enable`=2'b10, `d_wdata`=0xAB00.
  - `mem_write`=1, `mem_byte_enable`=2'b10, `mem_wdata`=0xAB00.
  - `d_resp` pulses with `mem_resp`.
- **Contention:** `if_read` and `d_read` both held high for 4 accesses.
  - Macro undefined: every grant is DATA while `d_read` is held; fetch is served only after `d_read` drops.
  - Macro defined: grants alternate DATA, FETCH, DATA, FETCH (`last_grant`=0 after reset).
- **Read and write together:** `d_read`=`d_write`=1 → `mem_write`=1, `mem_read`=0, `mem_byte_enable`=`d_byte_enable`.
- **Reset mid-access:** `rst_n`=0 during DATA before `mem_resp`.
  - Next cycle: all outputs are 0 and `busy`=0.
  - A `mem_resp` after that yields no `d_resp`.
- **Abort:** `if_read` dropped in FETCH before `mem_resp` → state returns to IDLE and `mem_read`=0 the next cycle; no `if_resp` is produced.
